// File: rtl/sixteen_bit_multiply_seq.sv
`default_nettype none
// ============================================================================
// Module   : sixteen_bit_multiply_seq
// Purpose  : Sequential signed 16x16 multiplier (shift-and-add, one partial
//            product per cycle). Returns the low 16 bits of the true signed
//            product plus an overflow flag when the product does not fit in
//            16-bit two's complement.
// Ports    : clk      - clock, rising edge
//            rst      - synchronous active-high reset
//            start    - request a multiply (sampled only while idle)
//            a, b     - two's-complement operands, captured on accepted start
//            busy     - operation in flight
//            done     - one-cycle completion pulse
//            product  - wrapped 16-bit product, held until next completion
//            overflow - product outside [-32768, 32767], held with product
// Revision : 1.0 - initial release
// ============================================================================
module sixteen_bit_multiply_seq (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic        busy,
  output logic        done,
  output logic [15:0] product,
  output logic        overflow
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_RUN    = 2'd1,
    S_FINISH = 2'd2
  } state_t;

  localparam logic [4:0] c_LAST_ITER = 5'd15;

  state_t      r_state;
  state_t      w_state_nxt;

  logic [31:0] r_mcand;   // multiplicand magnitude, shifted left each RUN cycle
  logic [15:0] r_mplier;  // multiplier magnitude, shifted right each RUN cycle
  logic [31:0] r_acc;
  logic [4:0]  r_cnt;
  logic        r_sign;
  logic        r_busy;
  logic        r_done;
  logic [15:0] r_product;
  logic        r_overflow;

  logic [15:0] w_abs_a;
  logic [15:0] w_abs_b;
  logic [31:0] w_p;
  logic        w_ovf;

  // Magnitudes as unsigned 16-bit values; |-32768| = 0x8000 is representable.
  assign w_abs_a = a[15] ? (~a + 16'd1) : a;
  assign w_abs_b = b[15] ? (~b + 16'd1) : b;

  // Signed result. A zero magnitude negates to zero, so no sign artefact.
  assign w_p   = r_sign ? (~r_acc + 32'd1) : r_acc;
  // Fits in 16 bits only when bits 31..15 are all copies of the sign bit.
  assign w_ovf = ~((&w_p[31:15]) | ~(|w_p[31:15]));

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        if (r_cnt == c_LAST_ITER) begin
          w_state_nxt = S_FINISH;
        end
      end
      S_FINISH: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Datapath and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      r_mcand    <= 32'd0;
      r_mplier   <= 16'd0;
      r_acc      <= 32'd0;
      r_cnt      <= 5'd0;
      r_sign     <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_product  <= 16'd0;
      r_overflow <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_mcand  <= {16'd0, w_abs_a};
            r_mplier <= w_abs_b;
            r_sign   <= a[15] ^ b[15];
            r_acc    <= 32'd0;
            r_cnt    <= 5'd0;
            r_busy   <= 1'b1;
          end
        end
        S_RUN: begin
          if (r_mplier[0]) begin
            r_acc <= r_acc + r_mcand;
          end
          r_mcand  <= {r_mcand[30:0], 1'b0};
          r_mplier <= {1'b0, r_mplier[15:1]};
          r_cnt    <= r_cnt + 5'd1;
        end
        S_FINISH: begin
          r_product  <= w_p[15:0];
          r_overflow <= w_ovf;
          r_done     <= 1'b1;
          r_busy     <= 1'b0;
        end
        default: begin
          r_busy <= 1'b0;
        end
      endcase
    end
  end

  assign busy     = r_busy;
  assign done     = r_done;
  assign product  = r_product;
  assign overflow = r_overflow;

endmodule
`default_nettype wire

// File: doc/sixteen_bit_multiply_seq.md
# sixteen_bit_multiply_seq

Sequential signed 16-bit multiplier: the repeated-addition counterpart to the datapath's combinational subtract and add units. It takes two's-complement operands through a start/busy/done handshake and computes the product with a shift-and-add loop, one partial product per cycle. It returns a 16-bit wrapped product and an overflow flag, using the same result/overflow convention as the adder and subtractor. It sits beside those units in the Lab1 ALU and is used where a multi-cycle multiply is acceptable.

## Interface
- Parameters: none (width fixed at 16).
- `clk` — in, 1 — single clock; all state updates on the rising edge.
- `rst` — in, 1 — synchronous, active-high reset.
- `start` — in, 1 — request a multiply; sampled only in IDLE.
- `a` — in, 16 — multiplicand, two's complement; captured on accepted start.
- `b` — in, 16 — multiplier, two's complement; captured on accepted start.
- `busy` — out, 1 — high from the cycle after an accepted start until `done` is asserted.
- `done` — out, 1 — one-cycle pulse; `product` and `overflow` are valid from this cycle.
- `product` — out, 16 — low 16 bits of the true signed product; held until the next completion.
- `overflow` — out, 1 — true product lies outside [-32768, 32767]; held with `product`.

## Operation
- States: IDLE, RUN, FINISH.
- IDLE, `start`=1:
  - capture |a| and |b| as 16-bit unsigned values (|-32768| = 0x8000 is exact);
  - capture sign = a[15]^b[15];
  - clear the 32-bit accumulator and the 5-bit counter;
  - go to RUN.
- IDLE, `start`=0: stay in IDLE; outputs hold.
- RUN, each cycle:
  - if the multiplier LSB is 1, accumulator += multiplicand (32-bit, no carry-out lost);
  - shift the multiplicand left by 1 and the multiplier right by 1;
  - increment the counter;
  - after the 16th RUN cycle (counter=15 at the edge), go to FINISH.
- FINISH:
  - P = sign ? -accumulator : accumulator (32-bit two's complement);
  - register `product` = P[15:0];
  - register `overflow` = (P[31:15] not all equal);
  - pulse `done`; return to IDLE.
- Zero operand: follows the normal path. The magnitude is 0, so P=0 with no sign artefact; product 0, overflow 0, even when sign=1.
- `start` while `busy` or in FINISH is ignored; no queueing.
- Operand changes after the accepting edge have no effect.
- Reset (any state, including mid-RUN):
  - state → IDLE;
  - `busy`, `done`, `overflow` → 0;
  - `product` → 0x0000;
  - accumulator and counter cleared;
  - the in-flight operation is discarded and never produces `done`.

## Timing
- Edge 0: start accepted in IDLE; `busy`=1 after edge 0.
- Edges 1–16: RUN iterations.
- Edge 17: FINISH results registered. `done`=1, `busy`=0 and the results are valid in the cycle after edge 17.
- Edge 18: `done` returns to 0; state is IDLE.
- Latency start→done: 18 cycles. Throughput: one multiply per 18 cycles; the earliest new start is the cycle `done` is high, which is accepted at edge 18.
- `start` held high continuously: back-to-back operations. Each captures the operands present at its accepting edge.
- All outputs are registered; no combinational path from inputs to outputs.

## Test plan
- Reset, then a=3, b=5, start one cycle → `busy` high for 17 cycles, `done` pulse 18 cycles after start, product=0x000F, overflow=0.
- a=-7 (0xFFF9), b=6 → product=0xFFD6 (-42), overflow=0. Also a=0, b=-1 → product=0x0000, overflow=0.
- a=256, b=128 → product=0x8000, overflow=1. a=-256, b=128 → product=0x8000, overflow=0 (exact -32768).
- a=0x8000, b=0xFFFF (-32768 × -1) → product=0x8000, overflow=1. a=0x8000, b=0x8000 → product=0x0000, overflow=1.
- Start a=2, b=3; pulse start with a=9, b=9 on cycle 5 while busy → single `done` with product=0x0006; second start is ignored.
- Start a=100, b=100; assert rst on cycle 8 → next cycle all outputs 0 and state IDLE; no `done` follows. A fresh a=4, b=-4 → product=0xFFF0, overflow=0.
